// File: rtl/dram_master.sv
// Load/store initiator for the shared-bus DRAM array; sub-word stores use read-modify-write.
// Define DRAM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses and add the rsp_error port.
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 12
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

module dram_master (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [1:0]                    req_size,
  input  logic                          req_signed,
  input  logic [`DRAM_ADDRESS_SIZE-1:0] req_addr,
  input  logic [`DRAM_WORD_SIZE-1:0]    req_wdata,
  output logic                          rsp_valid,
  output logic [`DRAM_WORD_SIZE-1:0]    rsp_rdata,
`ifdef DRAM_ALIGN_CHECK_EN
  output logic                          rsp_error,
`endif
  output logic [`DRAM_ADDRESS_SIZE-1:0] mem_address,
  output logic                          mem_wren,
  inout  wire  [`DRAM_WORD_SIZE-1:0]    mem_data
);

  localparam int unsigned AW = `DRAM_ADDRESS_SIZE;
  localparam int unsigned DW = `DRAM_WORD_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0]   mem_address_q, mem_address_d;
  logic            mem_wren_q, mem_wren_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic [15:0]     sdata_q, sdata_d;
`ifdef DRAM_ALIGN_CHECK_EN
  logic            err_q, err_d;
  logic            misaligned_c;
`endif

  // Extract and extend a load result from the captured bus word.
  function automatic logic [DW-1:0] load_ext(input logic [1:0] size, input logic sgn,
                                             input logic [DW-1:0] w);
    logic [DW-1:0] r;
    case (size)
      2'b00:   r = sgn ? {{(DW-8){w[7]}}, w[7:0]}    : {{(DW-8){1'b0}}, w[7:0]};
      2'b01:   r = sgn ? {{(DW-16){w[15]}}, w[15:0]} : {{(DW-16){1'b0}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Bus driven by this block only while the write-enable flop is set.
  assign mem_data = mem_wren_q ? wdata_q : {DW{1'bz}};

`ifdef DRAM_ALIGN_CHECK_EN
  always_comb begin
    misaligned_c = 1'b0;
    if (req_size == 2'b01)  misaligned_c = req_addr[0];
    else if (req_size[1])   misaligned_c = |req_addr[1:0];
  end
`endif

  always_comb begin
    state_d       = state_q;
    rsp_rdata_d   = rsp_rdata_q;
    mem_address_d = mem_address_q;
    mem_wren_d    = 1'b0;
    wdata_d       = wdata_q;
    size_d        = size_q;
    signed_d      = signed_q;
    sdata_d       = sdata_q;
`ifdef DRAM_ALIGN_CHECK_EN
    err_d         = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d        = req_size;
          signed_d      = req_signed;
          sdata_d       = req_wdata[15:0];
          mem_address_d = req_addr;
`ifdef DRAM_ALIGN_CHECK_EN
          if (misaligned_c) begin
            state_d     = ST_RESP;
            rsp_rdata_d = '0;
            err_d       = 1'b1;
          end else
`endif
          if (!req_write) begin
            state_d = ST_READ;
          end else if (req_size[1]) begin
            mem_wren_d = 1'b1;
            wdata_d    = req_wdata;
            state_d    = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_READ: begin
        rsp_rdata_d = load_ext(size_q, signed_q, mem_data);
        state_d     = ST_RESP;
      end
      // Keep the upper bytes read back, overlay the store data on the low lane(s).
      ST_RMW_RD: begin
        wdata_d    = size_q[0] ? {mem_data[DW-1:16], sdata_q} : {mem_data[DW-1:8], sdata_q[7:0]};
        mem_wren_d = 1'b1;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        rsp_rdata_d = '0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ready_q       <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_address_q <= '0;
      mem_wren_q    <= 1'b0;
      wdata_q       <= '0;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      sdata_q       <= '0;
`ifdef DRAM_ALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_wren_q    <= mem_wren_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      sdata_q       <= sdata_d;
`ifdef DRAM_ALIGN_CHECK_EN
      err_q         <= err_d;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_wren    = mem_wren_q;
`ifdef DRAM_ALIGN_CHECK_EN
  assign rsp_error   = err_q;
`endif

endmodule

// File: doc/dram_master.md
# dram_master

Initiator-side controller for the shared-bus DRAM array in the CPU's memory stage. Accepts one load/store request at a time from the pipeline and drives the array's `address`/`wren`/bidirectional `data` bus. Stores of less than a word use read-modify-write, because the array always writes four consecutive bytes. Load data is returned zero- or sign-extended with a single-cycle response pulse.

## Interface
Parameters (taken from `config.sv` / `constants.sv` macros, not module parameters):
- `DRAM_ADDRESS_SIZE`, from config: byte-address width of the array.
- `DRAM_WORD_SIZE`, 32: bus width; little-endian, byte at `addr` occupies `[7:0]`.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present; held by the pipeline until accepted.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid & req_ready` is true.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- `req_signed`  in  1  sign-extend sub-word loads.
- `req_addr`  in  `DRAM_ADDRESS_SIZE`  byte address.
- `req_wdata`  in  32  store data, low bytes significant for sub-word.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  load result, 0 for stores; valid with `rsp_valid`.
- `rsp_error`  out  1  misaligned-access flag; exists only when the feature in Configuration is compiled in.
- `mem_address`  out  `DRAM_ADDRESS_SIZE`  to the array's `address` input.
- `mem_wren`  out  1  to the array's `wren` input.
- `mem_data`  inout  32  to the array's `data` port; driven only while `mem_wren`=1, otherwise high-Z.

## Operation
- FSM states: IDLE, READ, RMW_RD, WRITE, RESP. `mem_address`, `mem_wren` and the write-data register are all flops.
- **IDLE.** On accept, latch the request, then branch:
  - Error (see Configuration): go to RESP.
  - Load: `mem_wren`<=0, `mem_address`<=addr, go to READ.
  - Word store: `mem_wren`<=1, write register<=`req_wdata`, go to WRITE.
  - Byte or halfword store: `mem_wren`<=0, go to RMW_RD.
- **READ.** The array drives `mem_data` combinationally. Capture it and extract the result:
  - byte: `[7:0]`
  - half: `[15:0]`
  - word: all 32 bits
  - Sub-word results are zero-extended, or sign-extended from bit 7/15 when `req_signed`=1.
  - Go to RESP.
- **RMW_RD.** Capture `mem_data` and replace `[7:0]` (byte) or `[15:0]` (half) with the store data, keeping the upper bytes. Then `mem_wren`<=1 and go to WRITE.
- **WRITE.** `mem_wren`=1 for exactly this cycle. The array commits on the closing edge. Then `mem_wren`<=0 and go to RESP.
- **RESP.** `rsp_valid`=1 for one cycle; `rsp_rdata` holds the load result (0 for stores). Go to IDLE.
- `req_valid` outside IDLE is ignored; the pipeline holds it.
- The bus is never driven by both ends: the array drives only when `wren`=0, and this block drives only when `mem_wren`=1, from the same flop.
- Address arithmetic is modulo 2^`DRAM_ADDRESS_SIZE`. Bytes at `addr+1..3` beyond the top of the array are not checked: reads of them are X and writes to them are lost.

## Timing
- Cycle 0 is the accept edge.
- `rsp_valid` asserts in:
  - cycle 2 for loads and word stores
  - cycle 3 for sub-word stores
  - cycle 1 for errored requests.
- Throughput: the next request is accepted in the cycle after RESP, i.e. one request per 3, 3, 4 or 2 cycles respectively.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `mem_wren`=0, `mem_address`=0, `mem_data` high-Z.
- Reset mid-operation:
  - Reset asserted during WRITE: the array still samples `mem_wren`=1 at that edge, so the write completes.
  - Reset in RMW_RD or READ: no write occurs.
  - In all cases there is no `rsp_valid`, and IDLE follows.

## Configuration
- `DRAM_ALIGN_CHECK_EN` defined:
  - half with `addr[0]`≠0, or word (and size 11) with `addr[1:0]`≠0, is rejected in IDLE.
  - RESP follows with `rsp_error`=1 and `rsp_rdata`=0.
  - `mem_wren` never asserts for that request.
  - `rsp_error` is 0 on all other responses.
- `DRAM_ALIGN_CHECK_EN` undefined:
  - no `rsp_error` port.
  - misaligned accesses are performed normally at byte granularity.

## Test plan
- Reset held 2 cycles -> all outputs at reset values, `req_ready`=1, `mem_data` high-Z from this block.
- Word store 0xDEADBEEF at 0x10, then word load at 0x10:
  - store: `mem_wren` high for exactly 1 cycle, `rsp_valid` in cycle 2.
  - load: `rsp_rdata`=0xDEADBEEF in cycle 2.
- Byte store `req_wdata`=0x1234565A at 0x11, then word load at 0x10 -> 0xDEAD5AEF; store `rsp_valid` in cycle 3.
- Loads after the previous steps:
  - signed byte at 0x13 -> 0xFFFFFFDE
  - unsigned byte at 0x13 -> 0x000000DE
  - signed half at 0x12 -> 0xFFFFDEAD
- Word store 0 at 0x14, then word load at 0x11:
  - with `DRAM_ALIGN_CHECK_EN`: `rsp_error`=1 in cycle 1, no write.
  - without: `rsp_rdata`=0x00DEAD5A.
- Byte store at 0x10 with reset asserted while in RMW_RD -> word at 0x10 unchanged (0xDEAD5AEF), no `rsp_valid`, `req_ready`=1 next cycle.
